// File: rtl/exec_muldiv_sequencer.sv
// exec_muldiv_sequencer: iterative RV32M multiply/divide unit that stalls EX until its result is ready
module exec_muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};
  state_t state, state_nxt;
  logic [2:0]        op_q;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_nxt, prod;
  logic [XLEN-1:0]   b_mag, a_mag, b_mag_in, fast_res, run_res, quo, rem;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic              neg_q, rneg_q, a_sgn, b_sgn, a_neg, b_neg, start_ok, fast, b_zero, ovf;
  always_comb begin
    a_sgn    = i_op == 3'b001 || i_op == 3'b010 || i_op == 3'b100 || i_op == 3'b110;
    b_sgn    = i_op == 3'b001 || i_op == 3'b100 || i_op == 3'b110;
    a_neg    = a_sgn & i_src_a[XLEN-1];
    b_neg    = b_sgn & i_src_b[XLEN-1];
    a_mag    = a_neg ? -i_src_a : i_src_a;
    b_mag_in = b_neg ? -i_src_b : i_src_b;
    start_ok = i_start & ~i_flush;
    b_zero   = i_src_b == '0;
    ovf      = ~i_op[0] & (i_src_a == MIN) & (i_src_b == ONES);
    fast     = i_op[2] & (b_zero | ovf);
    fast_res = b_zero ? (i_op[1] ? i_src_a : ONES) : (i_op[1] ? '0 : i_src_a);
    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, b_mag};
    acc_nxt  = !op_q[2] ? {mul_sum, acc[XLEN-1:1]} :
               diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0} :
                            {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    prod     = neg_q ? -acc_nxt : acc_nxt;
    quo      = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem      = rneg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    run_res  = !op_q[2] ? (op_q == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
               (op_q[1] ? rem : quo);
    o_busy   = ~i_reset & (state == RUN || (state == IDLE && start_ok));
    o_done   = state == DONE;
    state_nxt = state == IDLE ? (start_ok ? (fast ? DONE : RUN) : IDLE) :
                state == RUN  ? (i_flush ? IDLE : (cnt == '0 ? DONE : RUN)) : IDLE;
  end
  always_ff @(posedge i_clk)
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt      <= '0;
      o_result <= '0;
      acc      <= '0;
      b_mag    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else if (state == IDLE && start_ok) begin
      op_q   <= i_op;
      b_mag  <= b_mag_in;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      acc    <= {{XLEN{1'b0}}, a_mag};
      cnt    <= CNT_W'(XLEN-1);
      if (fast) o_result <= fast_res;
    end else if (state == RUN && !i_flush) begin
      acc <= acc_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == '0) o_result <= run_res;
    end
  end
endmodule

// File: tb/tb_exec_muldiv_sequencer.sv
// tb_exec_muldiv_sequencer: randomized and directed checks against a native-arithmetic reference model
module tb_exec_muldiv_sequencer;
  localparam logic [31:0] MIN = 32'h8000_0000;
  logic        i_clk = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_flush = 1'b0;
  logic [2:0]  i_op = 3'd0;
  logic [31:0] i_src_a = '0, i_src_b = '0;
  logic        o_busy, o_done;
  logic [31:0] o_result;
  int checks = 0, errors = 0;

  exec_muldiv_sequencer #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_src_a(i_src_a), .i_src_b(i_src_b), .i_flush(i_flush),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result));

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pa, pb, p;
    int sa, sb;
    sa = a;
    sb = b;
    pa = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    pb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = pa * pb;
    case (op)
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : (a == MIN && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a : (a == MIN && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op[2] && (b == 0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF))) ? 1 : 33;
  endfunction

  // Starts an op in the next cycle, scrambles operands while it runs, and checks timing and result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] exp;
    int lat, done_cyc, busy_cnt;
    exp = ref_result(op, a, b);
    lat = ref_latency(op, a, b);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_op = op; i_src_a = a; i_src_b = b;
    @(negedge i_clk);
    checks++;
    if (o_done !== 1'b0) begin errors++; $display("FAIL %s idle_done: got %b expected 0", name, o_done); end
    busy_cnt = int'(o_busy);
    done_cyc = -1;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      @(posedge i_clk); #1;
      i_op = 3'($urandom); i_src_a = $urandom; i_src_b = $urandom;
      @(negedge i_clk);
      if (o_busy) busy_cnt++;
      if (o_done) done_cyc = c;
    end
    i_start = 1'b0;
    checks++;
    if (done_cyc != lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, done_cyc, lat); end
    checks++;
    if (busy_cnt != lat) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, lat); end
    checks++;
    if (o_result !== exp) begin errors++; $display("FAIL %s result: got %h expected %h", name, o_result, exp); end
  endtask

  task automatic watch_idle(input int n, input string name);
    int seen;
    seen = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge i_clk);
      if (o_done || o_busy) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL %s quiet: got %0d active cycles expected 0", name, seen); end
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_start = 1'b1; i_op = 3'd4; i_src_a = 32'd5; i_src_b = 32'd0;
    @(posedge i_clk); @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    checks++;
    if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", o_done); end
    checks++;
    if (o_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", o_result); end
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_start = 1'b0;
    watch_idle(3, "post_reset");
  endtask

  task automatic test_directed;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
    run_op(3'd1, MIN, MIN, "mulh_min");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, "remu_100_7");
  endtask

  task automatic test_fast_path;
    run_op(3'd4, 32'd5, 32'd0, "div_by_zero");
    run_op(3'd7, 32'd5, 32'd0, "remu_by_zero");
    run_op(3'd5, 32'd5, 32'd0, "divu_by_zero");
    run_op(3'd6, 32'd9, 32'd0, "rem_by_zero");
    run_op(3'd4, MIN, 32'hFFFF_FFFF, "div_overflow");
    run_op(3'd6, MIN, 32'hFFFF_FFFF, "rem_overflow");
    run_op(3'd5, MIN, 32'hFFFF_FFFF, "divu_min_ones");
  endtask

  task automatic test_random;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = MIN; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      run_op(op, a, b, $sformatf("rand%0d_op%0d", n, op));
    end
  endtask

  task automatic test_flush;
    run_op(3'd0, 32'd5, 32'd6, "flush_prior");
    @(posedge i_clk); #1;
    i_start = 1'b1; i_op = 3'd0; i_src_a = 32'd7; i_src_b = 32'd9;
    for (int c = 1; c <= 10; c++) begin
      @(posedge i_clk); #1;
      if (c == 10) begin i_flush = 1'b1; i_start = 1'b0; end
    end
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    watch_idle(40, "flush_run");
    checks++;
    if (o_result !== 32'd30) begin errors++; $display("FAIL flush_result_kept: got %h expected %h", o_result, 32'd30); end
    @(posedge i_clk); #1;
    i_start = 1'b1; i_flush = 1'b1; i_op = 3'd5; i_src_a = 32'd8; i_src_b = 32'd2;
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b expected 0", o_busy); end
    @(posedge i_clk); #1;
    i_start = 1'b0; i_flush = 1'b0;
    watch_idle(40, "flush_start");
    run_op(3'd5, 32'd9, 32'd3, "divu_after_flush");
  endtask

  task automatic test_reset_mid;
    run_op(3'd0, 32'd3, 32'd4, "reset_prior");
    @(posedge i_clk); #1;
    i_start = 1'b1; i_op = 3'd4; i_src_a = 32'd100; i_src_b = 32'd7;
    for (int c = 1; c <= 20; c++) begin
      @(posedge i_clk); #1;
      if (c == 20) i_reset = 1'b1;
    end
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", o_busy); end
    @(posedge i_clk); #1;
    @(negedge i_clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL midreset_flags: got done=%b busy=%b expected 0 0", o_done, o_busy); end
    checks++;
    if (o_result !== 32'd0) begin errors++; $display("FAIL midreset_result: got %h expected 0", o_result); end
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_start = 1'b0;
    watch_idle(40, "midreset_idle");
    run_op(3'd5, 32'd100, 32'd7, "divu_after_reset");
  endtask

  task automatic test_back_to_back;
    run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, "b2b_mulhu");
    run_op(3'd6, 32'h8000_0001, 32'hFFFF_FFFD, "b2b_rem");
    run_op(3'd4, 32'd1, 32'd0, "b2b_fast");
    run_op(3'd4, 32'hFFFF_FF00, 32'd16, "b2b_div");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_fast_path;
    test_back_to_back;
    test_random;
    test_flush;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
